// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
//   Shared definitions for the pipelined ALU slice.
//   - OP_* : 3-bit opcodes understood by alu_core / alu_pipe.
//   - alu_flags_t : packed result flags {zero, negative, overflow, carry}.
//   - FLAGS_CLEAR : all-zero flag value used at reset.
// ---------------------------------------------------------------------------
package alu_pkg;

  localparam logic [2:0] OP_AND    = 3'b000;
  localparam logic [2:0] OP_ADD    = 3'b001;
  localparam logic [2:0] OP_SUB    = 3'b010;
  localparam logic [2:0] OP_SUBINV = 3'b011;
  localparam logic [2:0] OP_OR     = 3'b100;
  localparam logic [2:0] OP_XOR    = 3'b101;
  localparam logic [2:0] OP_SLT    = 3'b110;
  localparam logic [2:0] OP_PASSB  = 3'b111;

  typedef struct packed {
    logic zero;
    logic negative;
    logic overflow;
    logic carry;
  } alu_flags_t;

  localparam alu_flags_t FLAGS_CLEAR = '{zero: 1'b0, negative: 1'b0,
                                         overflow: 1'b0, carry: 1'b0};

endpackage

// File: rtl/alu_core.sv
// ---------------------------------------------------------------------------
// alu_core
//   Purely combinational ALU datapath: result plus zero/negative/overflow/
//   carry flags for one operation.
//   Configuration macro: ALU_PIPE_SAT_EN
//     defined   -> ADD/SUB/SUBINV clamp to the signed max/min on overflow
//     undefined -> results wrap modulo 2^WIDTH
//   Parameters:
//     WIDTH    operand/result width in bits (>= 4)
//   Ports:
//     op       in   3      opcode (alu_pkg::OP_*)
//     a        in   WIDTH  operand A
//     b        in   WIDTH  operand B
//     y        out  WIDTH  result
//     zero     out  1      y == 0
//     negative out  1      y[WIDTH-1]
//     overflow out  1      signed overflow of ADD/SUB/SUBINV, else 0
//     carry    out  1      ADD carry-out, SUB/SUBINV no-borrow, else 0
// ---------------------------------------------------------------------------
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic             negative,
  output logic             overflow,
  output logic             carry
);

  localparam int MSB = WIDTH - 1;
  localparam logic [WIDTH:0] ONE = {{WIDTH{1'b0}}, 1'b1};

  logic [WIDTH:0]   sum_ab;
  logic [WIDTH:0]   diff_ab;
  logic [WIDTH:0]   diff_ba;
  logic             v_add;
  logic             v_sub;
  logic             v_subinv;
  logic             a_lt_b;
  logic [WIDTH-1:0] raw;
  logic [WIDTH-1:0] result;
  logic             v_sel;
  logic             c_sel;

  // All arithmetic is done one bit wider than the operands so that the top
  // bit is the carry-out. Subtraction is a + ~b + 1, so its top bit is the
  // no-borrow indication (1 when the minuend is unsigned >= subtrahend).
  assign sum_ab  = {1'b0, a} + {1'b0, b};
  assign diff_ab = {1'b0, a} + {1'b0, ~b} + ONE;
  assign diff_ba = {1'b0, b} + {1'b0, ~a} + ONE;

  // Signed overflow: for an add both operands share a sign that the result
  // lost; for a subtract the operands differ in sign and the result sign
  // differs from the minuend.
  assign v_add    = (a[MSB] == b[MSB]) && (sum_ab[MSB]  != a[MSB]);
  assign v_sub    = (a[MSB] != b[MSB]) && (diff_ab[MSB] != a[MSB]);
  assign v_subinv = (a[MSB] != b[MSB]) && (diff_ba[MSB] != b[MSB]);

  // Signed less-than taken from the sign of a-b corrected by its overflow,
  // so it stays right even when a-b itself does not fit in WIDTH bits.
  assign a_lt_b = diff_ab[MSB] ^ v_sub;

  // Opcode decode into the wrapped result and the raw overflow/carry.
  always_comb begin
    raw   = '0;
    v_sel = 1'b0;
    c_sel = 1'b0;
    case (op)
      OP_AND:    raw = a & b;
      OP_ADD: begin
        raw   = sum_ab[MSB:0];
        v_sel = v_add;
        c_sel = sum_ab[WIDTH];
      end
      OP_SUB: begin
        raw   = diff_ab[MSB:0];
        v_sel = v_sub;
        c_sel = diff_ab[WIDTH];
      end
      OP_SUBINV: begin
        raw   = diff_ba[MSB:0];
        v_sel = v_subinv;
        c_sel = diff_ba[WIDTH];
      end
      OP_OR:     raw = a | b;
      OP_XOR:    raw = a ^ b;
      OP_SLT:    raw = {{(WIDTH-1){1'b0}}, a_lt_b};
      OP_PASSB:  raw = b;
      default:   raw = '0;
    endcase
  end

`ifdef ALU_PIPE_SAT_EN
  localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {MSB{1'b1}}};
  localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {MSB{1'b0}}};

  // Only ADD/SUB/SUBINV can raise v_sel. A wrapped result that looks
  // negative means the true value overflowed upward, and vice versa.
  always_comb begin
    result = raw;
    if (v_sel) begin
      result = raw[MSB] ? SAT_MAX : SAT_MIN;
    end
  end
`else
  // Wrapping build: the modulo-2^WIDTH result goes straight out.
  always_comb begin
    result = raw;
  end
`endif

  // Zero/negative always describe the value actually presented on y.
  assign y        = result;
  assign zero     = (result == '0);
  assign negative = result[MSB];
  assign overflow = v_sel;
  assign carry    = c_sel;

endmodule

// File: rtl/alu_pipe.sv
// ---------------------------------------------------------------------------
// alu_pipe
//   Two-stage pipelined ALU with valid/ready handshakes on both sides.
//   Stage 1 registers op/a/b; stage 2 registers the alu_core result and
//   flags. An op accepted in cycle N is presented in cycle N+2, and one op
//   per cycle is sustained while the consumer keeps out_ready high.
//   Configuration macro: ALU_PIPE_SAT_EN (saturating ADD/SUB/SUBINV, handled
//   inside alu_core).
//   Parameters:
//     WIDTH     operand/result width in bits (>= 4)
//   Ports:
//     clk       in   1      rising-edge clock
//     rst_n     in   1      asynchronous active-low reset
//     in_valid  in   1      op/a/b valid
//     in_ready  out  1      accepting; transfer on in_valid && in_ready
//     op        in   3      opcode (alu_pkg::OP_*)
//     a         in   WIDTH  operand A
//     b         in   WIDTH  operand B
//     out_valid out  1      y and flags valid
//     out_ready in   1      consumer accepts; transfer on out_valid && out_ready
//     y         out  WIDTH  result
//     zero      out  1      y == 0
//     negative  out  1      y[WIDTH-1]
//     overflow  out  1      signed overflow of the operation
//     carry     out  1      ADD carry-out, SUB/SUBINV no-borrow, else 0
// ---------------------------------------------------------------------------
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic             negative,
  output logic             overflow,
  output logic             carry
);

  logic             s1_valid;
  logic [2:0]       s1_op;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;

  logic             s2_valid;
  logic [WIDTH-1:0] s2_y;
  alu_flags_t       s2_flags;

  logic             s1_advance;
  logic             s2_advance;

  logic [WIDTH-1:0] core_y;
  logic             core_zero;
  logic             core_negative;
  logic             core_overflow;
  logic             core_carry;

  // A stage may take new data when it is empty or its content leaves this
  // cycle. The chain is combinational from out_ready back to in_ready, which
  // is what lets accept and emit happen on the same beat without a bubble.
  assign s2_advance = !s2_valid || out_ready;
  assign s1_advance = !s1_valid || s2_advance;
  assign in_ready   = s1_advance;

  alu_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .op       (s1_op),
    .a        (s1_a),
    .b        (s1_b),
    .y        (core_y),
    .zero     (core_zero),
    .negative (core_negative),
    .overflow (core_overflow),
    .carry    (core_carry)
  );

  // Stage 1: operand capture. Payload is only loaded on a real transfer so
  // the registers keep their last value while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_op    <= OP_AND;
      s1_a     <= '0;
      s1_b     <= '0;
    end else if (s1_advance) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_op <= op;
        s1_a  <= a;
        s1_b  <= b;
      end
    end
  end

  // Stage 2: result register. Holding while stalled keeps y and flags
  // stable for the consumer; reset discards anything in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_y     <= '0;
      s2_flags <= FLAGS_CLEAR;
    end else if (s2_advance) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_y     <= core_y;
        s2_flags <= '{zero:     core_zero,
                      negative: core_negative,
                      overflow: core_overflow,
                      carry:    core_carry};
      end
    end
  end

  assign out_valid = s2_valid;
  assign y         = s2_y;
  assign zero      = s2_flags.zero;
  assign negative  = s2_flags.negative;
  assign overflow  = s2_flags.overflow;
  assign carry     = s2_flags.carry;

endmodule

// File: tb/tb_alu_pipe.sv
// ---------------------------------------------------------------------------
// tb_alu_pipe
//   Self-checking bench for alu_pipe (WIDTH=16). Stimulus pushes the
//   expected response into a scoreboard queue at the moment of transfer; an
//   independent monitor compares every presented beat against the queue
//   head and pops it when the consumer takes it.
//   Honours ALU_PIPE_SAT_EN for the saturating expectations.
// ---------------------------------------------------------------------------
module tb_alu_pipe;

  localparam int W = 16;

  localparam logic [2:0] T_AND    = 3'd0;
  localparam logic [2:0] T_ADD    = 3'd1;
  localparam logic [2:0] T_SUB    = 3'd2;
  localparam logic [2:0] T_SUBINV = 3'd3;
  localparam logic [2:0] T_OR     = 3'd4;
  localparam logic [2:0] T_XOR    = 3'd5;
  localparam logic [2:0] T_SLT    = 3'd6;
  localparam logic [2:0] T_PASSB  = 3'd7;

  typedef struct {
    logic [W-1:0] y;
    logic [3:0]   flags;
    int           acc_cyc;
    bit           chk_lat;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] y;
  logic         zero;
  logic         negative;
  logic         overflow;
  logic         carry;

  exp_t sb_q[$];
  int   total_checks;
  int   bad_checks;
  int   cyc;
  int   ready_mode;

  alu_pipe #(
    .WIDTH (W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .zero      (zero),
    .negative  (negative),
    .overflow  (overflow),
    .carry     (carry)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Consumer model: 0 = stall, 1 = always ready, 2 = random back-pressure.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = ($urandom_range(0, 9) < 7);
      endcase
    end
  end

  initial begin
    #5000000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference model: true signed/unsigned integer results, then wrap or clamp.
  function automatic exp_t model(input logic [2:0] o, input logic [W-1:0] av,
                                 input logic [W-1:0] bv);
    exp_t   e;
    int     sa;
    int     sb;
    int     ua;
    int     ub;
    int     full;
    logic   v;
    logic   c;
    logic [W-1:0] r;
    sa   = $signed(av);
    sb   = $signed(bv);
    ua   = int'(av);
    ub   = int'(bv);
    full = 0;
    v    = 1'b0;
    c    = 1'b0;
    r    = '0;
    case (o)
      T_AND:    r = av & bv;
      T_OR:     r = av | bv;
      T_XOR:    r = av ^ bv;
      T_PASSB:  r = bv;
      T_SLT:    r = (sa < sb) ? 16'd1 : 16'd0;
      T_ADD:    begin full = sa + sb; c = (ua + ub) > 65535; end
      T_SUB:    begin full = sa - sb; c = (ua >= ub); end
      default:  begin full = sb - sa; c = (ub >= ua); end
    endcase
    if (o == T_ADD || o == T_SUB || o == T_SUBINV) begin
      v = (full > 32767) || (full < -32768);
      r = full[W-1:0];
`ifdef ALU_PIPE_SAT_EN
      if (v) r = (full > 32767) ? 16'h7FFF : 16'h8000;
`endif
    end
    e.y       = r;
    e.flags   = {(r == 16'd0), r[W-1], v, c};
    e.acc_cyc = 0;
    e.chk_lat = 1'b0;
    return e;
  endfunction

  task automatic checkSignal(input string name, input logic [31:0] act,
                             input logic [31:0] req);
    total_checks++;
    if (act !== req) begin
      bad_checks++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Drive one op and hold it until accepted; push the expectation on transfer.
  task automatic applyStimulus(input logic [2:0] o, input logic [W-1:0] av,
                               input logic [W-1:0] bv, input bit use_exp,
                               input logic [W-1:0] ey, input logic [3:0] ef,
                               input bit lat);
    exp_t e;
    int   n;
    in_valid = 1'b1;
    op       = o;
    a        = av;
    b        = bv;
    n        = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 200);
    if (!in_ready) begin
      checkSignal("accept_timeout", 32'(in_ready), 32'd1);
    end else begin
      e = model(o, av, bv);
      if (use_exp) begin
        e.y     = ey;
        e.flags = ef;
      end
      e.acc_cyc = cyc;
      e.chk_lat = lat;
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Compare the presented beat with the oldest outstanding expectation.
  task automatic checkOutput();
    exp_t e;
    if (sb_q.size() == 0) begin
      checkSignal("unexpected_output", 32'(out_valid), 32'd0);
    end else begin
      e = sb_q[0];
      checkSignal("y", 32'(y), 32'(e.y));
      checkSignal("flags_znvc", 32'({zero, negative, overflow, carry}),
                  32'(e.flags));
      if (e.chk_lat) begin
        checkSignal("latency", 32'(cyc - e.acc_cyc), 32'd2);
        sb_q[0].chk_lat = 1'b0;
      end
      if (out_ready) void'(sb_q.pop_front());
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && out_valid) checkOutput();
    end
  end

  task automatic waitDrain(input string name);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    checkSignal(name, 32'(sb_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int busy;
    total_checks = 0;
    bad_checks   = 0;
    ready_mode   = 1;
    rst_n        = 1'b1;
    in_valid     = 1'b0;
    op           = 3'd0;
    a            = '0;
    b            = '0;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkSignal("rst_in_ready", 32'(in_ready), 32'd1);
    checkSignal("rst_out_valid", 32'(out_valid), 32'd0);
    checkSignal("rst_y", 32'(y), 32'd0);
    checkSignal("rst_flags", 32'({zero, negative, overflow, carry}), 32'd0);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] back-to-back ADD/SUB");
    applyStimulus(T_ADD, 16'd3, 16'd4, 1'b1, 16'h0007, 4'b0000, 1'b1);
    applyStimulus(T_SUB, 16'd3, 16'd4, 1'b1, 16'hFFFF, 4'b0100, 1'b1);
    waitDrain("drain_b2b");

    $display("[TB] overflow boundaries and SLT");
`ifdef ALU_PIPE_SAT_EN
    applyStimulus(T_ADD, 16'h7FFF, 16'h0001, 1'b1, 16'h7FFF, 4'b0010, 1'b0);
    applyStimulus(T_SUBINV, 16'h0001, 16'h8000, 1'b1, 16'h8000, 4'b0111, 1'b0);
`else
    applyStimulus(T_ADD, 16'h7FFF, 16'h0001, 1'b1, 16'h8000, 4'b0110, 1'b0);
    applyStimulus(T_SUBINV, 16'h0001, 16'h8000, 1'b1, 16'h7FFF, 4'b0011, 1'b0);
`endif
    applyStimulus(T_SLT, 16'h8000, 16'h0001, 1'b1, 16'h0001, 4'b0000, 1'b0);
    applyStimulus(T_SLT, 16'h0005, 16'h0005, 1'b1, 16'h0000, 4'b1000, 1'b0);
    applyStimulus(T_SUB, 16'h0005, 16'h0005, 1'b1, 16'h0000, 4'b1001, 1'b0);
    waitDrain("drain_boundary");

    $display("[TB] stall with three ops");
    ready_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    applyStimulus(T_XOR, 16'hA5A5, 16'h0FF0, 1'b0, '0, '0, 1'b0);
    applyStimulus(T_OR, 16'h1200, 16'h0034, 1'b0, '0, '0, 1'b0);
    @(negedge clk);
    checkSignal("stall_in_ready", 32'(in_ready), 32'd0);
    fork
      applyStimulus(T_PASSB, 16'h1111, 16'hBEEF, 1'b0, '0, '0, 1'b0);
      begin
        repeat (4) @(posedge clk);
        ready_mode = 1;
      end
    join
    waitDrain("drain_stall");

    $display("[TB] reset with ops in flight");
    ready_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    applyStimulus(T_ADD, 16'd10, 16'd20, 1'b0, '0, '0, 1'b0);
    applyStimulus(T_AND, 16'hFF00, 16'h0F0F, 1'b0, '0, '0, 1'b0);
    #2 rst_n = 1'b0;
    sb_q.delete();
    #1;
    checkSignal("midrst_out_valid", 32'(out_valid), 32'd0);
    checkSignal("midrst_in_ready", 32'(in_ready), 32'd1);
    checkSignal("midrst_y", 32'(y), 32'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    ready_mode = 1;
    busy = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) busy++;
    end
    checkSignal("dropped_ops_emitted", 32'(busy), 32'd0);
    @(posedge clk);
    #1;

    $display("[TB] random traffic");
    ready_mode = 2;
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        @(posedge clk);
        #1;
      end
      applyStimulus(3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom),
                    1'b0, '0, '0, 1'b0);
    end
    waitDrain("drain_random");
    ready_mode = 1;
    repeat (2) @(posedge clk);

    $display("[TB] test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule
